// File: rtl/lnu_sched_pkg.sv
// lnu_sched_pkg: shared state encoding and sizing helpers for the
// unicast injection scheduler and its round-robin arbiter.
package lnu_sched_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SEND  = 2'd1;
  localparam state_t STALL = 2'd2;

  localparam int PERF_CNT_W = 16;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/linear_network_unicast_sched_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester after ptr.
// Pure combinational; the owner keeps and advances the pointer.
module rr_arbiter
  import lnu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      idx,
  output logic               any
);

  int c;

  // scan from ptr+1 upward with wrap; first hit wins
  always_comb begin
    grant = '0;
    idx   = ptr;
    any   = 1'b0;
    c     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = PW'(c);
      end
    end
  end

endmodule

// File: rtl/linear_network_unicast_sched.sv
// linear_network_unicast_sched: arbitrates NUM_REQ producers onto one
// network injection port. LNU_SCHED_PERF_EN adds grant/stall counters.
module linear_network_unicast_sched
  import lnu_sched_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_NODE      = 4,
  parameter int NUM_REQ       = 4,
  parameter int COMMAND_WIDTH = $clog2(NUM_NODE)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    i_req_data,
  input  logic [NUM_REQ*COMMAND_WIDTH-1:0] i_req_dest,
  output logic [NUM_REQ-1:0]               o_req_ready,
  input  logic                             i_stall,
  output logic                             o_net_valid,
  output logic [DATA_WIDTH-1:0]            o_net_data,
  output logic                             o_net_en,
  output logic [COMMAND_WIDTH-1:0]         o_net_cmd,
  output logic                             o_err
`ifdef LNU_SCHED_PERF_EN
  ,
  output logic [NUM_REQ*PERF_CNT_W-1:0]    o_grant_cnt,
  output logic [31:0]                      o_stall_cycles
`endif
);

  localparam int PW = ptr_width(NUM_REQ);

  state_t state;
  state_t state_nx;

  logic [PW-1:0]            ptr;
  logic [NUM_REQ-1:0]       grant;
  logic [PW-1:0]            idx;
  logic                     any;
  logic                     allow;
  logic                     xfer;
  logic                     bad;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [COMMAND_WIDTH-1:0] sel_dest;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_arb (
    .req   (i_req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (idx),
    .any   (any)
  );

  // grant only when the network is free to advance this cycle
  always_comb begin
    allow       = rst_n && (state != STALL) && !i_stall;
    o_req_ready = allow ? grant : '0;
    xfer        = allow && any;
    sel_data    = i_req_data[idx*DATA_WIDTH +: DATA_WIDTH];
    sel_dest    = i_req_dest[idx*COMMAND_WIDTH +: COMMAND_WIDTH];
    bad         = 32'(sel_dest) >= 32'(NUM_NODE);
  end

  // next-state: stall dominates, stall release returns to SEND
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      i_stall:                      state_nx = STALL;
      !i_stall && state == STALL:   state_nx = SEND;
      xfer:                         state_nx = SEND;
      default:                      state_nx = IDLE;
    endcase
  end

  // FSM, rr pointer, output word register and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= PW'(NUM_REQ - 1);
      o_net_valid <= 1'b0;
      o_net_data  <= '0;
      o_net_cmd   <= '0;
      o_net_en    <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state    <= state_nx;
      o_net_en <= (state_nx != STALL);
      if (allow) begin
        if (xfer) begin
          ptr <= idx;
          if (bad) begin
            o_net_valid <= 1'b0;
            o_err       <= 1'b1;
          end else begin
            o_net_valid <= 1'b1;
            o_net_data  <= sel_data;
            o_net_cmd   <= sel_dest;
          end
        end else begin
          o_net_valid <= 1'b0;
        end
      end
    end
  end

`ifdef LNU_SCHED_PERF_EN
  logic [PERF_CNT_W-1:0] gcnt [NUM_REQ];

  // saturating per-requester grant counts, wrapping stall cycle count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REQ; r++) gcnt[r] <= '0;
      o_stall_cycles <= '0;
    end else begin
      for (int r = 0; r < NUM_REQ; r++)
        if (xfer && idx == PW'(r) && gcnt[r] != '1)
          gcnt[r] <= gcnt[r] + 1'b1;
      if (state == STALL)
        o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign o_grant_cnt[g*PERF_CNT_W +: PERF_CNT_W] = gcnt[g];
  end
`endif

endmodule

// File: tb/tb_linear_network_unicast_sched.sv
// tb_linear_network_unicast_sched: scoreboard bench, NUM_NODE=3 so the
// out-of-range destination path is reachable.
module tb_linear_network_unicast_sched;

  localparam int NR = 4;
  localparam int NN = 3;
  localparam int DW = 32;
  localparam int CW = 2;

  typedef struct packed {
    logic          bad;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NR-1:0]    req_valid;
  logic [DW-1:0]    rd   [NR];
  logic [CW-1:0]    rdst [NR];
  logic [NR*DW-1:0] req_data;
  logic [NR*CW-1:0] req_dest;
  logic [NR-1:0]    req_ready;
  logic             stall;
  logic             net_valid;
  logic [DW-1:0]    net_data;
  logic             net_en;
  logic [CW-1:0]    net_cmd;
  logic             err;
`ifdef LNU_SCHED_PERF_EN
  logic [NR*16-1:0] grant_cnt;
  logic [31:0]      stall_cycles;
`endif

  assign req_data = {rd[3], rd[2], rd[1], rd[0]};
  assign req_dest = {rdst[3], rdst[2], rdst[1], rdst[0]};

  always #5 clk = ~clk;

  linear_network_unicast_sched #(
    .DATA_WIDTH (DW),
    .NUM_NODE   (NN),
    .NUM_REQ    (NR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .i_req_dest  (req_dest),
    .o_req_ready (req_ready),
    .i_stall     (stall),
    .o_net_valid (net_valid),
    .o_net_data  (net_data),
    .o_net_en    (net_en),
    .o_net_cmd   (net_cmd),
    .o_err       (err)
`ifdef LNU_SCHED_PERF_EN
    ,
    .o_grant_cnt    (grant_cnt),
    .o_stall_cycles (stall_cycles)
`endif
  );

  int checks = 0;
  int failures = 0;

  exp_t          q[$];
  logic [NR-1:0] obs[$];
  int            m_ptr;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [CW-1:0] m_cmd;
  logic          m_en;
  logic          m_err;
  logic          m_st;
  int            m_scyc;
  logic [15:0]   cnt [NR];

  task automatic m_reset();
    m_ptr = NR - 1;
    m_valid = 1'b0;
    m_data = '0;
    m_cmd = '0;
    m_en = 1'b0;
    m_err = 1'b0;
    m_st = 1'b0;
    m_scyc = 0;
    q.delete();
    for (int r = 0; r < NR; r++) cnt[r] = '0;
  endtask

  // one clock: predict grant, push expectation, then check outputs
  task automatic step();
    int gi;
    int c;
    logic allow;
    logic [NR-1:0] eg;
    logic [NR-1:0] seen;
    exp_t e;
    @(negedge clk);
    allow = rst_n && !m_st && !stall;
    gi = -1;
    eg = '0;
    if (allow)
      for (int k = 1; k <= NR; k++) begin
        c = (m_ptr + k) % NR;
        if (gi < 0 && req_valid[c]) gi = c;
      end
    if (gi >= 0) eg[gi] = 1'b1;
    seen = req_ready;
    obs.push_back(seen);
    checks++;
    if (seen !== eg) begin
      failures++;
      $display("FAIL req_ready: got %b want %b", seen, eg);
    end
    if (gi >= 0) begin
      e.bad = (32'(rdst[gi]) >= NN);
      e.d = rd[gi];
      e.c = rdst[gi];
      q.push_back(e);
      m_ptr = gi;
      if (cnt[gi] != 16'hFFFF) cnt[gi] = cnt[gi] + 16'd1;
    end
    @(posedge clk);
    #1;
    if (m_st) m_scyc++;
    if (allow) begin
      if (gi >= 0) begin
        e = q.pop_front();
        if (e.bad) begin
          m_valid = 1'b0;
          m_err = 1'b1;
        end else begin
          m_valid = 1'b1;
          m_data = e.d;
          m_cmd = e.c;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    m_en = !stall;
    m_st = stall;
    checks += 5;
    if (net_valid !== m_valid) begin
      failures++;
      $display("FAIL net_valid: got %b want %b", net_valid, m_valid);
    end
    if (net_data !== m_data) begin
      failures++;
      $display("FAIL net_data: got %h want %h", net_data, m_data);
    end
    if (net_cmd !== m_cmd) begin
      failures++;
      $display("FAIL net_cmd: got %0d want %0d", net_cmd, m_cmd);
    end
    if (net_en !== m_en) begin
      failures++;
      $display("FAIL net_en: got %b want %b", net_en, m_en);
    end
    if (err !== m_err) begin
      failures++;
      $display("FAIL err: got %b want %b", err, m_err);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int r = 0; r < NR; r++) begin
      rd[r] = 32'h5000_0000 + r;
      rdst[r] = CW'(r % NN);
    end
    rst_n = 1'b0;
    req_valid = '1;
    stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL rst_ready: got %b want 0000", req_ready);
    end
    if (net_valid !== 1'b0 || net_en !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL rst_flags: got v%b e%b r%b want 000", net_valid, net_en, err);
    end
    if (net_data !== 32'h0) begin
      failures++;
      $display("FAIL rst_data: got %h want 0", net_data);
    end
    if (net_cmd !== 2'd0) begin
      failures++;
      $display("FAIL rst_cmd: got %0d want 0", net_cmd);
    end
    if (net_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid: got %b want 0", net_valid);
    end
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL rst_err: got %b want 0", err);
    end
    req_valid = 4'b0100;
    rst_n = 1'b1;
    m_reset();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (net_valid !== 1'b0 || net_en !== 1'b0) begin
      failures++;
      $display("FAIL async_rst_flags: got v%b e%b want 00", net_valid, net_en);
    end
    if (net_data !== 32'h0) begin
      failures++;
      $display("FAIL async_rst_data: got %h want 0", net_data);
    end
    if (net_cmd !== 2'd0) begin
      failures++;
      $display("FAIL async_rst_cmd: got %0d want 0", net_cmd);
    end
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL async_rst_ready: got %b want 0000", req_ready);
    end
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_valid = '1;
    obs.delete();
    step();
    checks++;
    if (obs[0] !== 4'b0001) begin
      failures++;
      $display("FAIL first_grant: got %b want 0001", obs[0]);
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_single();
    rd[1] = 32'hAAAA_AAAA;
    rdst[1] = 2'd2;
    req_valid = 4'b0010;
    obs.delete();
    repeat (3) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== 4'b0010) begin
        failures++;
        $display("FAIL single_ready[%0d]: got %b want 0010", i, obs[i]);
      end
    end
    req_valid = '0;
    step();
  endtask

  task automatic test_fairness();
    do_reset();
    for (int r = 0; r < NR; r++) begin
      rd[r] = 32'h1000_0000 + r;
      rdst[r] = CW'(r % NN);
    end
    req_valid = '1;
    obs.delete();
    repeat (8) step();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs[i] !== NR'(1 << (i % NR))) begin
        failures++;
        $display("FAIL rr_order[%0d]: got %b want %b", i, obs[i], NR'(1 << (i % NR)));
      end
    end
`ifdef LNU_SCHED_PERF_EN
    checks++;
    if (grant_cnt !== {16'd2, 16'd2, 16'd2, 16'd2}) begin
      failures++;
      $display("FAIL grant_cnt: got %h want 0002000200020002", grant_cnt);
    end
`endif
  endtask

  task automatic test_stall();
    rd[0] = 32'hBBBB_BBBB;
    rdst[0] = 2'd1;
    req_valid = 4'b0001;
    step();
    req_valid = 4'b0011;
    stall = 1'b1;
    repeat (5) step();
    checks++;
    if (net_data !== 32'hBBBB_BBBB || net_cmd !== 2'd1) begin
      failures++;
      $display("FAIL stall_frozen: got %h/%0d want bbbbbbbb/1", net_data, net_cmd);
    end
    stall = 1'b0;
    step();
    obs.delete();
    step();
    checks++;
    if (obs[0] !== 4'b0010) begin
      failures++;
      $display("FAIL stall_resume: got %b want 0010", obs[0]);
    end
`ifdef LNU_SCHED_PERF_EN
    checks++;
    if (stall_cycles !== 32'd5) begin
      failures++;
      $display("FAIL stall_cycles: got %0d want 5", stall_cycles);
    end
`endif
    req_valid = '0;
    step();
  endtask

  task automatic test_bad_dest();
    rd[2] = 32'hCCCC_CCCC;
    rdst[2] = 2'd3;
    req_valid = 4'b0100;
    obs.delete();
    step();
    checks += 2;
    if (obs[0] !== 4'b0100) begin
      failures++;
      $display("FAIL bad_handshake: got %b want 0100", obs[0]);
    end
    if (net_valid !== 1'b0 || err !== 1'b1) begin
      failures++;
      $display("FAIL bad_drop: got v%b e%b want v0 e1", net_valid, err);
    end
    rd[2] = 32'hDDDD_DDDD;
    rdst[2] = 2'd0;
    step();
    checks++;
    if (net_data !== 32'hDDDD_DDDD || net_valid !== 1'b1 || err !== 1'b1) begin
      failures++;
      $display("FAIL bad_next: got %h v%b e%b want dddddddd v1 e1", net_data, net_valid, err);
    end
    req_valid = '0;
    step();
    step();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_bad_dest();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
